fetch_stage: RTL and testbench

Parametrised instruction-fetch stage for the pipelined RISC-V core: owns the program counter, drives the instruction-memory address, and buffers fetched {pc, instr} pairs in a DEPTH-entry queue feeding decode through a valid/ready handshake. Decode redirects the PC with the shared PC-op encodings (PCClear, PCAdd4, PCAddImm, PCSetImm from the common defines file). Redirects flush the queue. Compared with the single-register fetch path it replaces, this block adds back-pressure, buffering, a configurable reset vector and misalignment detection.

---
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, imem address and DEPTH-entry {pc, instr} queue to decode
// Redirects flush the queue and load an aligned target; misalign flags dropped low target bits.
module fetch_stage #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic [ADDR_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0]   imem_rdata,
  input  logic                     redir_valid,
  input  logic [2:0]               redir_op,
  input  logic [ADDR_WIDTH-1:0]    redir_base,
  input  logic [ADDR_WIDTH-1:0]    redir_imm,
  output logic                     id_valid,
  input  logic                     id_ready,
  output logic [INSTR_WIDTH-1:0]   id_instr,
  output logic [ADDR_WIDTH-1:0]    id_pc,
  output logic [$clog2(DEPTH):0]   q_count,
  output logic                     misalign
);

  localparam logic [2:0] PC_CLEAR   = 3'd0;
  localparam logic [2:0] PC_ADD4    = 3'd1;
  localparam logic [2:0] PC_ADD_IMM = 3'd2;
  localparam logic [2:0] PC_SET_IMM = 3'd3;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INSTR_WIDTH / 8);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = STEP - ADDR_WIDTH'(1);
  localparam logic [CNT_W-1:0]      FULL       = CNT_W'(DEPTH);

  logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   misalign_q, misalign_d;
  logic [ADDR_WIDTH-1:0]  pc_mem_q    [DEPTH];
  logic [INSTR_WIDTH-1:0] instr_mem_q [DEPTH];

  logic                  redirect, push, pop;
  logic [ADDR_WIDTH-1:0] target;

  always_comb begin
    redirect   = 1'b0;
    target     = pc_q;
    pc_d       = pc_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    misalign_d = 1'b0;

    if (redir_valid) begin
      case (redir_op)
        PC_CLEAR:   begin redirect = 1'b1; target = RESET_PC; end
        PC_ADD_IMM: begin redirect = 1'b1; target = redir_base + redir_imm; end
        PC_SET_IMM: begin redirect = 1'b1; target = redir_imm; end
        PC_ADD4:    redirect = 1'b0;
        default:    redirect = 1'b0;
      endcase
    end

    pop  = (count_q != '0) && id_ready;
    // A full queue can still accept a fetch when the head leaves in the same cycle.
    push = !redirect && ((count_q < FULL) || pop);

    if (redirect) begin
      pc_d       = target & ~ALIGN_MASK;
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      misalign_d = |(target & ALIGN_MASK);
    end else begin
      if (push) begin
        tail_d = tail_q + PTR_W'(1);
        pc_d   = pc_q + STEP;
      end
      if (pop) begin
        head_d = head_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      pc_mem_q[tail_q]    <= pc_q;
      instr_mem_q[tail_q] <= imem_rdata;
    end
  end

  assign imem_addr = pc_q;
  assign id_valid  = (count_q != '0);
  assign id_pc     = pc_mem_q[head_q];
  assign id_instr  = instr_mem_q[head_q];
  assign q_count   = count_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - scoreboard bench for fetch_stage (RESET_PC = 0x80, DEPTH = 2)
// Stimulus queues expected head PCs; a negedge monitor checks every accepted head against them.
module tb_fetch_stage;

  localparam logic [2:0] PC_CLEAR   = 3'd0;
  localparam logic [2:0] PC_ADD4    = 3'd1;
  localparam logic [2:0] PC_ADD_IMM = 3'd2;
  localparam logic [2:0] PC_SET_IMM = 3'd3;
  localparam logic [31:0] RST_PC    = 32'h0000_0080;
  localparam logic [31:0] MAGIC     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [2:0]  redir_op;
  logic [31:0] redir_base;
  logic [31:0] redir_imm;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [1:0]  q_count;
  logic        misalign;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_q [$];

  fetch_stage #(
    .ADDR_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(2), .RESET_PC(RST_PC)
  ) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redir_valid(redir_valid), .redir_op(redir_op), .redir_base(redir_base),
    .redir_imm(redir_imm), .id_valid(id_valid), .id_ready(id_ready),
    .id_instr(id_instr), .id_pc(id_pc), .q_count(q_count), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Instruction memory: data derived from the address so id_instr can be predicted.
  assign imem_rdata = imem_addr ^ MAGIC;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_drained(input int budget);
    int cyc = 0;
    id_ready = 1'b1;
    while (exp_q.size() != 0 && cyc < budget) begin
      cycle();
      cyc++;
    end
    id_ready = 1'b0;
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic redirect(input logic [2:0] op, input logic [31:0] base, input logic [31:0] imm);
    id_ready    = 1'b0;
    redir_valid = 1'b1;
    redir_op    = op;
    redir_base  = base;
    redir_imm   = imm;
    check("sb_empty_before_redirect", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    cycle();
    redir_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (id_valid === 1'b1 && id_ready === 1'b1) begin
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_head: got pc %h, expected no output", id_pc);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (id_pc !== e || id_instr !== (e ^ MAGIC)) begin
          tests_failed++;
          $display("FAIL head_entry: got pc %h instr %h, expected pc %h instr %h",
                   id_pc, id_instr, e, e ^ MAGIC);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; id_ready = 1'b0; redir_valid = 1'b0;
    redir_op = PC_ADD4; redir_base = '0; redir_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_id_valid", 32'(id_valid), 32'd0);
    check("rst_q_count", 32'(q_count), 32'd0);
    check("rst_misalign", 32'(misalign), 32'd0);
    check("rst_imem_addr", imem_addr, RST_PC);

    // Streaming from reset: one per cycle, occupancy 1.
    reset = 1'b0;
    id_ready = 1'b1;
    expect_seq(RST_PC, 7);
    for (int i = 0; i < 7; i++) begin
      cycle();
      check("stream_valid", 32'(id_valid), 32'd1);
      check("stream_count", 32'(q_count), 32'd1);
    end
    cycle();
    id_ready = 1'b0;
    check("stream_drained", 32'(exp_q.size()), 32'd0);

    // Back-pressure: queue fills, fetch address holds.
    repeat (4) cycle();
    check("stall_count", 32'(q_count), 32'd2);
    check("stall_imem_addr", imem_addr, 32'h0000_00A4);
    check("stall_head_pc", id_pc, 32'h0000_009C);
    id_ready = 1'b1;
    expect_seq(32'h0000_009C, 4);
    for (int j = 0; j < 4; j++) begin
      check("full_poppush_count", 32'(q_count), 32'd2);
      check("full_poppush_valid", 32'(id_valid), 32'd1);
      cycle();
    end
    id_ready = 1'b0;
    check("full_drained", 32'(exp_q.size()), 32'd0);

    // PCAddImm redirect: 2-cycle penalty, old entries discarded.
    redirect(PC_ADD_IMM, 32'h0000_0100, 32'h0000_0020);
    expect_seq(32'h0000_0120, 2);
    check("addimm_valid_t1", 32'(id_valid), 32'd0);
    check("addimm_count_t1", 32'(q_count), 32'd0);
    check("addimm_misalign", 32'(misalign), 32'd0);
    check("addimm_imem_addr", imem_addr, 32'h0000_0120);
    cycle();
    check("addimm_valid_t2", 32'(id_valid), 32'd1);
    run_until_drained(10);

    // PCSetImm misaligned: pulse for exactly one cycle.
    redirect(PC_SET_IMM, 32'h0, 32'h0000_0203);
    expect_seq(32'h0000_0200, 2);
    check("setimm_misalign_t1", 32'(misalign), 32'd1);
    check("setimm_imem_addr", imem_addr, 32'h0000_0200);
    cycle();
    check("setimm_misalign_t2", 32'(misalign), 32'd0);
    check("setimm_valid_t2", 32'(id_valid), 32'd1);
    run_until_drained(10);

    // PCClear returns to the reset vector.
    redirect(PC_CLEAR, 32'h0000_1000, 32'h0000_0555);
    expect_seq(RST_PC, 2);
    check("clear_imem_addr", imem_addr, RST_PC);
    check("clear_misalign", 32'(misalign), 32'd0);
    run_until_drained(10);

    // PC wraps to zero at the top of the address space.
    redirect(PC_SET_IMM, 32'h0, 32'hFFFF_FFF8);
    expect_seq(32'hFFFF_FFF8, 4);
    run_until_drained(12);

    // PCAdd4 and an unknown op with redir_valid leave the stream untouched.
    redirect(PC_SET_IMM, 32'h0, 32'h0000_0400);
    id_ready = 1'b1;
    expect_seq(32'h0000_0400, 8);
    cycle();
    for (int k = 0; k < 8; k++) begin
      redir_valid = (k == 1 || k == 2);
      redir_op    = (k == 2) ? 3'd7 : PC_ADD4;
      redir_imm   = 32'h0000_0999;
      check("noop_redir_valid", 32'(id_valid), 32'd1);
      cycle();
    end
    redir_valid = 1'b0;
    id_ready = 1'b0;
    check("noop_drained", 32'(exp_q.size()), 32'd0);

    // Reset wins over a concurrent redirect.
    exp_q.delete();
    reset = 1'b1;
    redir_valid = 1'b1;
    redir_op = PC_SET_IMM;
    redir_imm = 32'h0000_0303;
    cycle();
    redir_valid = 1'b0;
    check("rst_redir_valid", 32'(id_valid), 32'd0);
    check("rst_redir_count", 32'(q_count), 32'd0);
    check("rst_redir_misalign", 32'(misalign), 32'd0);
    check("rst_redir_imem_addr", imem_addr, RST_PC);
    reset = 1'b0;
    expect_seq(RST_PC, 3);
    run_until_drained(10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
